// File: rtl/keyboard_event_queue.sv
// ---------------------------------------------------------------------------
// keyboard_event_queue
//
// Turns the toggle-strobe PS/2 key bus from hps_io into discrete events and
// queues them in a small first-word-fall-through FIFO that the CPU drains
// through its I/O port decoder. A burst of keystrokes therefore is not lost
// when it arrives faster than the CPU polls.
//
// Pipeline: a toggle on ps2_key[10] is detected and its payload is captured
// at edge N. The entry is written at edge N+1.
//
// Optional feature macro: KEYQ_REPEAT_FILTER_EN
//   defined   - A 512-bit held-key map drops typematic repeats. This is a
//               press of a key that is already held. Releases are always
//               queued.
//   undefined - Every event is queued.
//
// Ports:
//   clk_sys   in   system clock, rising edge
//   reset     in   synchronous active-high reset
//   ps2_key   in   [10] toggle strobe, [9] pressed, [8] extended, [7:0] scancode
//   rd_pop    in   pop head entry (ignored when empty)
//   flush     in   discard all queued entries
//   ovf_clr   in   clear sticky overflow
//   rd_data   out  head entry {pressed, extended, scancode}, 0 when empty
//   empty     out  no entries queued
//   count     out  number of queued entries
//   overflow  out  sticky: an event was dropped on a full queue
// ---------------------------------------------------------------------------
module keyboard_event_queue #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk_sys,
  input  logic                  reset,
  input  logic [10:0]           ps2_key,
  input  logic                  rd_pop,
  input  logic                  flush,
  input  logic                  ovf_clr,
  output logic [9:0]            rd_data,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow
);

  localparam int                DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL = (DEPTH_LOG2 + 1)'(DEPTH);

  logic                  tog_q;
  logic                  ev_q;      // event detected at the previous edge
  logic [9:0]            ev_data;   // payload captured with that event
  logic [9:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wp;
  logic [DEPTH_LOG2-1:0] rp;

  logic push_req;
  logic push_ok;
  logic pop_ok;
  logic drop;

`ifdef KEYQ_REPEAT_FILTER_EN
  logic [511:0] held;
  logic [8:0]   key_idx;

  assign key_idx  = ev_data[8:0];
  // A press of a key that is already held is a typematic repeat. It is
  // discarded silently and does not count as an overflow.
  assign push_req = ev_q && !(ev_data[9] && held[key_idx]);

  // The map follows every event, even when the push is dropped because the
  // queue is full. Only reset clears the map; a flush leaves it intact.
  always_ff @(posedge clk_sys) begin
    if (reset)
      held <= '0;
    else if (ev_q)
      held[key_idx] <= ev_data[9];
  end
`else
  assign push_req = ev_q;
`endif

  assign pop_ok  = rd_pop && (count != '0);
  // When the queue is full, a push is still accepted if a pop frees a slot
  // at the same edge.
  assign push_ok = push_req && ((count != FULL) || pop_ok);
  assign drop    = push_req && !push_ok && !flush;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      // Loading the current strobe level means that releasing reset does
      // not create an event.
      tog_q    <= ps2_key[10];
      ev_q     <= 1'b0;
      ev_data  <= '0;
      wp       <= '0;
      rp       <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      tog_q   <= ps2_key[10];
      // An event that is detected together with a flush is discarded along
      // with the queue contents.
      ev_q    <= (ps2_key[10] != tog_q) && !flush;
      ev_data <= ps2_key[9:0];

      if (flush) begin
        wp    <= '0;
        rp    <= '0;
        count <= '0;
      end else begin
        if (push_ok) wp <= wp + 1'b1;
        if (pop_ok)  rp <= rp + 1'b1;
        unique case ({push_ok, pop_ok})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end

      // If an event is dropped at the same edge as ovf_clr, the set wins.
      if (drop)
        overflow <= 1'b1;
      else if (ovf_clr)
        overflow <= 1'b0;
    end
  end

  // NOTE: the storage array has no reset. Entries are only visible through
  // count/rp, so stale contents are harmless, and leaving the array without
  // a reset lets it map onto RAM-style cells.
  always_ff @(posedge clk_sys) begin
    if (!reset && !flush && push_ok)
      mem[wp] <= ev_data;
  end

  assign empty   = (count == '0);
  assign rd_data = empty ? '0 : mem[rp];

endmodule

// File: tb/tb_keyboard_event_queue.sv
// ---------------------------------------------------------------------------
// tb_keyboard_event_queue
//
// Directed bench for keyboard_event_queue with DEPTH_LOG2 = 4. The expected
// values are written out by hand. The repeat-filter expectations follow
// KEYQ_REPEAT_FILTER_EN, so the same bench covers both builds.
// ---------------------------------------------------------------------------
module tb_keyboard_event_queue;

  localparam int DEPTH_LOG2 = 4;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic [10:0] ps2_key;
  logic        rd_pop;
  logic        flush;
  logic        ovf_clr;
  logic [9:0]  rd_data;
  logic        empty;
  logic [DEPTH_LOG2:0] count;
  logic        overflow;

  int n_checks = 0;
  int n_fail   = 0;

  keyboard_event_queue #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .ps2_key  (ps2_key),
    .rd_pop   (rd_pop),
    .flush    (flush),
    .ovf_clr  (ovf_clr),
    .rd_data  (rd_data),
    .empty    (empty),
    .count    (count),
    .overflow (overflow)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge. Inputs are driven and outputs are sampled 1ns later.
  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  // Flip the strobe with a new payload. The toggle is detected at this edge
  // and the entry is written at the next one.
  task automatic send(input logic [9:0] payload);
    ps2_key = {~ps2_key[10], payload};
    step();
  endtask

  logic [9:0] exp_q[$];

  initial begin
    reset   = 1'b1;
    ps2_key = 11'h400;
    rd_pop  = 1'b0;
    flush   = 1'b0;
    ovf_clr = 1'b0;
    step(); step();
    reset = 1'b0;
    step(); step(); step();

    // Releasing reset with the strobe high must not create an event.
    check("rst_empty",    32'(empty),    32'd1);
    check("rst_count",    32'(count),    32'd0);
    check("rst_rd_data",  32'(rd_data),  32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);

    // Single event, then pop it.
    send(10'h21C);
    check("lat_not_yet",  32'(count),    32'd0);
    step();
    check("one_count",    32'(count),    32'd1);
    check("one_data",     32'(rd_data),  32'h21C);
    check("one_empty",    32'(empty),    32'd0);
    rd_pop = 1'b1; step(); rd_pop = 1'b0;
    check("pop_empty",    32'(empty),    32'd1);
    check("pop_data",     32'(rd_data),  32'd0);
    // A pop on an empty queue is ignored.
    rd_pop = 1'b1; step(); rd_pop = 1'b0;
    check("pop_on_empty", 32'(count),    32'd0);

    // 17 back-to-back releases: 16 fit, the last one is dropped.
    for (int i = 0; i < 17; i++) send(10'(10'h100 + i));
    step();
    check("full_count",   32'(count),    32'd16);
    check("full_ovf",     32'(overflow), 32'd1);
    check("full_head",    32'(rd_data),  32'h100);
    ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
    check("ovf_clr",      32'(overflow), 32'd0);

    // Full queue: a push at the same edge as a pop keeps the count at 16.
    ps2_key = {~ps2_key[10], 10'h0AA};
    step();
    rd_pop = 1'b1; step(); rd_pop = 1'b0;
    check("fp_count",     32'(count),    32'd16);
    check("fp_ovf",       32'(overflow), 32'd0);
    check("fp_head",      32'(rd_data),  32'h101);
    rd_pop = 1'b1;
    for (int i = 0; i < 15; i++) begin
      check("fp_drain", 32'(rd_data), 32'(10'h101 + i));
      step();
    end
    check("fp_tail",      32'(rd_data),  32'h0AA);
    step();
    rd_pop = 1'b0;
    check("fp_drained",   32'(empty),    32'd1);

    // Push and pop on an empty queue at the same edge: the pop is ignored.
    ps2_key = {~ps2_key[10], 10'h155};
    step();
    rd_pop = 1'b1; step(); rd_pop = 1'b0;
    check("pp_empty_cnt", 32'(count),    32'd1);
    check("pp_empty_dat", 32'(rd_data),  32'h155);

    // Flush with 5 entries and a toggle in the same cycle.
    for (int i = 0; i < 4; i++) send(10'(10'h0B0 + i));
    step();
    check("pre_flush",    32'(count),    32'd5);
    ps2_key = {~ps2_key[10], 10'h0BF};
    flush   = 1'b1; step(); flush = 1'b0;
    check("flush_count",  32'(count),    32'd0);
    check("flush_empty",  32'(empty),    32'd1);
    check("flush_data",   32'(rd_data),  32'd0);
    step();
    check("flush_no_ev",  32'(count),    32'd0);
    // The strobe tracking continued through the flush.
    send(10'h0D0);
    step();
    check("post_flush",   32'(rd_data),  32'h0D0);
    rd_pop = 1'b1; step(); rd_pop = 1'b0;
    check("post_flush_e", 32'(empty),    32'd1);

    // Drop and ovf_clr at the same edge: the set wins.
    for (int i = 0; i < 16; i++) send(10'(10'h0C0 + i));
    step();
    check("refill",       32'(count),    32'd16);
    ps2_key = {~ps2_key[10], 10'h0CF};
    step();
    ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
    check("ovf_set_wins", 32'(overflow), 32'd1);
    check("ovf_cnt",      32'(count),    32'd16);

    // Reset in the middle of operation, with a toggle pending.
    ps2_key = {~ps2_key[10], 10'h0EE};
    reset = 1'b1; step(); reset = 1'b0;
    check("mid_rst_cnt",  32'(count),    32'd0);
    check("mid_rst_ovf",  32'(overflow), 32'd0);
    step(); step();
    check("mid_rst_noev", 32'(empty),    32'd1);

    // Typematic repeats: three presses, then one release, of scancode 0x1C.
    send(10'h21C); send(10'h21C); send(10'h21C); send(10'h01C);
    step();
`ifdef KEYQ_REPEAT_FILTER_EN
    exp_q = '{10'h21C, 10'h01C};
`else
    exp_q = '{10'h21C, 10'h21C, 10'h21C, 10'h01C};
`endif
    check("rep_count",    32'(count),    32'(exp_q.size()));
    check("rep_ovf",      32'(overflow), 32'd0);
    rd_pop = 1'b1;
    foreach (exp_q[i]) begin
      check("rep_entry", 32'(rd_data), 32'(exp_q[i]));
      step();
    end
    rd_pop = 1'b0;
    check("rep_drained",  32'(empty),    32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/keyboard_event_queue.md
# keyboard_event_queue

Buffers PS/2 key events delivered by `hps_io` on the 11-bit `ps2_key` bus into a small FIFO that the `system` CPU drains through its I/O port decoder. Sits between `hps_io` and `system` in `emu`, on `clk_sys`. Converts the toggle-strobe protocol into discrete queued events so the CPU cannot miss keystrokes arriving faster than it polls.

## Interface
- `DEPTH_LOG2`, 4: FIFO depth is 2^DEPTH_LOG2 entries; legal range 2..8.
- `clk_sys`  in  1  system clock; all logic is on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `ps2_key`  in  11  from `hps_io`: [10] toggle strobe, [9] pressed, [8] extended, [7:0] scancode.
- `rd_pop`  in  1  pops the head entry on this edge; ignored when `empty`.
- `flush`  in  1  discards all queued entries.
- `ovf_clr`  in  1  clears `overflow`.
- `rd_data`  out  10  head entry {pressed, extended, scancode}; 0 when `empty`.
- `empty`  out  1  no entries queued.
- `count`  out  DEPTH_LOG2+1  entries queued.
- `overflow`  out  1  sticky: an event was dropped because the queue was full.

## Operation
- Edge detect: register `tog_q`; an event occurs in the cycle where `ps2_key[10] != tog_q`. `tog_q` follows `ps2_key[10]` every cycle. During reset `tog_q` loads `ps2_key[10]`, so no event is generated by the reset release itself.
- Event payload `ps2_key[9:0]` is captured in the event cycle.
- Storage: circular buffer, write pointer `wp`, read pointer `rp`, both DEPTH_LOG2 bits, wrapping modulo depth; `count` held explicitly.
- Push accepted when `count < depth`, or when `count == depth` and `rd_pop` is asserted in the same cycle (pop and push both happen; `count` unchanged).
- Push while full without pop: event dropped, `overflow` set to 1, pointers unchanged.
- Pop on empty: ignored; no pointer change, no error flag.
- Push and pop on empty queue in same cycle: pop ignored, push accepted; `count` becomes 1.
- `rd_data` is first-word-fall-through: reflects storage at `rp` combinationally when `count != 0`, else 0.
- `flush`: `wp`, `rp`, `count` to 0 at the edge; a push or pop in the same cycle is discarded; `overflow` untouched; `tog_q` still updates.
- `ovf_clr` clears `overflow`; if a drop occurs in the same cycle, set wins.
- Priority per edge: `reset` > `flush` > push/pop.

## Timing
- Reset values: `empty`=1, `count`=0, `overflow`=0, `rd_data`=0; key-held map (see Configuration) all 0.
- Latency: `ps2_key[10]` changes before edge N; event detected in cycle after edge N; entry written at edge N+1; `empty` deasserts and `rd_data` valid after edge N+1.
- Pop at edge M: new head on `rd_data` after edge M, zero wait.
- Back-to-back toggles on consecutive cycles each produce one event; throughput one event per cycle.
- Reset mid-operation: queue contents lost, no partial write completes.

## Configuration
- `KEYQ_REPEAT_FILTER_EN` defined: a 512-bit held map indexed by {extended, scancode}. Press event for a key already held is discarded (no push, no `overflow`); press of a non-held key sets its bit; release clears its bit and is always queued. Map updates even if the push is dropped for fullness. Map cleared by `reset`, not by `flush`.
- Not defined: no map; every event, including typematic repeats, is queued.

## Test plan
- Reset with `ps2_key[10]`=1, release -> no event; `empty`=1, `count`=0.
- Toggle with payload 10'h21C (press, 'A'), wait one cycle -> `count`=1, `rd_data`=10'h21C; pop -> `empty`=1, `rd_data`=0.
- DEPTH_LOG2=4: 17 toggles without pops -> `count`=16, `overflow`=1, head is first event; `ovf_clr` -> `overflow`=0.
- Full queue, toggle with simultaneous `rd_pop` -> `count` stays 16, new tail equals pushed payload, `overflow` stays 0.
- `flush` with 5 entries and simultaneous toggle -> `count`=0, `empty`=1.
- With `KEYQ_REPEAT_FILTER_EN`: press 0x1C three times, release 0x1C -> exactly two entries, 10'h21C then 10'h01C; without macro -> four entries.
